div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, which the single-cycle ALU does not implement.
- Sits beside the ALU in the execute stage, driven by the issue logic over a valid/ready request channel, and returns one result per request over a valid/ready response channel.
- Performs one radix-2 restoring iteration per cycle under a small FSM.
- Detects divide-by-zero and signed overflow and resolves them in a single cycle.

Parameters:
- XLEN, 32, operand and result width; the iteration counter is $clog2(XLEN)+1 bits.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline kill; abandons any in-flight operation
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- funct  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (instruction funct3[1:0])
- op1  in  XLEN  dividend
- op2  in  XLEN  divisor
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- result  out  XLEN  quotient or remainder

Behaviour:
- States: IDLE, CALC, DONE. On reset the FSM enters IDLE and outputs are req_ready=1, resp_valid=0, result=0, counter=0.
- IDLE
  - req_ready=1; resp_valid=0.
  - Handshake when req_valid && req_ready in cycle T: latch funct and the operand signs.
  - Fast path, divisor zero: quotient = all ones; remainder = op1. Go to DONE.
  - Fast path, signed overflow (funct signed, op1 = 0x80000000, op2 = 0xFFFFFFFF): quotient = 0x80000000; remainder = 0. Go to DONE.
  - Otherwise load |op1| and |op2| (raw values for the unsigned functs), clear the partial remainder and counter, and go to CALC.
- CALC
  - req_ready=0.
  - Each cycle: shift the partial remainder left, bringing in the dividend MSB; trial-subtract the divisor; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
  - Counter increments each cycle; after exactly XLEN cycles go to DONE.
- DONE
  - resp_valid=1; req_ready=0.
  - result is registered on DONE entry and held stable until handshake.
  - Signed quotient is negated when the operand signs differ. Signed remainder takes the dividend's sign.
  - REM/REMU return the remainder; DIV/DIVU return the quotient.
  - On resp_valid && resp_ready go to IDLE. No new request is accepted in the handshake cycle (req_ready=0 while in DONE).
- Latency, request accepted at edge T:
  - Normal path: resp_valid first high in cycle T+XLEN+1 (T+33).
  - Fast path: resp_valid first high in cycle T+1.
- Throughput: one request outstanding at a time.
- Back-pressure: resp_ready low holds DONE indefinitely; result, resp_valid=1 and req_ready=0 all stay unchanged.
- flush
  - Sampled in every state; next state is IDLE and resp_valid=0 in the following cycle. Any partial or completed result is discarded.
  - Flush in the same cycle as a request handshake: the request is dropped.
  - Flush has priority over resp handshake and over CALC completion.
- reset mid-operation: same as flush; additionally result is cleared to 0.
- Operands are not required to stay stable after the handshake; all needed values are latched internally.
- Arithmetic is XLEN-bit with modulo wrap for negation (−0x80000000 = 0x80000000). The partial remainder uses XLEN+1 bits for the trial subtraction.

Test Plan:
- DIVU 100/7 accepted at T → resp_valid at T+33, result 14. Repeat with REMU → result 2.
- DIV 0xFFFFFFF9(−7)/2 → 0xFFFFFFFD(−3). REM same operands → 0xFFFFFFFF(−1). REM 7/0xFFFFFFFE(−2) → 1.
- DIVU 5/0 → result 0xFFFFFFFF at T+1. REMU 5/0 → 5 at T+1. DIV 0xFFFFFFF6(−10)/0 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1. REM same operands → 0 at T+1.
- DIVU 0xFFFFFFFF/1 with resp_ready held low 5 cycles after resp_valid → result stays 0xFFFFFFFF, req_ready=0 throughout; handshake on cycle 6, req_ready=1 the next cycle.
- Flush asserted 10 cycles into CALC → IDLE next cycle, no resp_valid for that request. Then REMU 20/3 → 2 at +33. Repeat the interrupt using reset instead of flush → result=0, req_ready=1 the following cycle.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Request/response channel between the issue logic and the divide sequencer.
// Both directions use valid/ready handshakes; operands travel with the request.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      funct;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;

  modport master (
    output req_valid, funct, op1, op2, resp_ready,
    input  req_ready, resp_valid, result
  );

  modport slave (
    input  req_valid, funct, op1, op2, resp_ready,
    output req_ready, resp_valid, result
  );
endinterface

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring, one bit per cycle, XLEN+1 cycles
// to response (1 for divide-by-zero/overflow); holds the result in DONE until resp_ready.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  div_sequencer_if.slave io
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [1:0]      funct_q, funct_d;
  logic            neg1_q, neg1_d;
  logic            neg2_q, neg2_d;

  logic            sgn_in, op1_neg, op2_neg, ovf;
  logic [XLEN:0]   rem_shift, trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_next, quo_next, rem_fix, quo_fix;

  // The dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
  always_comb begin
    sgn_in    = ~io.funct[0];
    op1_neg   = sgn_in & io.op1[XLEN-1];
    op2_neg   = sgn_in & io.op2[XLEN-1];
    ovf       = sgn_in && (io.op1 == MIN_INT) && (io.op2 == '1);

    rem_shift = {rem_q, dvd_q[XLEN-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    q_bit     = ~trial[XLEN];
    rem_next  = q_bit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_next  = {dvd_q[XLEN-2:0], q_bit};
    quo_fix   = (neg1_q ^ neg2_q) ? -quo_next : quo_next;
    rem_fix   = neg1_q ? -rem_next : rem_next;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    result_d = result_q;
    funct_d  = funct_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;

    unique case (state_q)
      IDLE: begin
        if (io.req_valid) begin
          funct_d = io.funct;
          neg1_d  = op1_neg;
          neg2_d  = op2_neg;
          if (io.op2 == '0) begin
            result_d = io.funct[1] ? io.op1 : '1;
            state_d  = DONE;
          end else if (ovf) begin
            result_d = io.funct[1] ? '0 : MIN_INT;
            state_d  = DONE;
          end else begin
            dvd_d   = op1_neg ? -io.op1 : io.op1;
            dvs_d   = op2_neg ? -io.op2 : io.op2;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = funct_q[1] ? rem_fix : quo_fix;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (io.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Kill wins over request acceptance, completion and response handshake alike.
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      funct_q  <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      funct_q  <= funct_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
    end
  end

  assign io.req_ready  = (state_q == IDLE);
  assign io.resp_valid = (state_q == DONE);
  assign io.result     = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, arithmetic corner cases, back-pressure, flush and reset.
module tb_div_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  div_sequencer_if #(.XLEN(32)) bus ();

  div_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshake a request, scramble the operand bus, then count edges until resp_valid.
  task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.funct     = f;
    bus.op1       = a;
    bus.op2       = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.op1       = 32'hDEAD_BEEF;
    bus.op2       = 32'h1234_5678;
    bus.funct     = ~f;
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " req_ready in DONE"}, {31'b0, bus.req_ready}, 32'd0);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({tag, " resp_valid after take"}, {31'b0, bus.resp_valid}, 32'd0);
    check({tag, " req_ready after take"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.funct      = 2'b00;
    bus.op1        = '0;
    bus.op2        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("reset result", bus.result, 32'd0);

    run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32, 32'd14);               take("DIVU 100/7");
    run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 32, 32'd2);                take("REMU 100/7");
    run_op("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFD);    take("DIV -7/2");
    run_op("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF);    take("REM -7/2");
    run_op("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32, 32'd1);            take("REM 7/-2");
    run_op("DIVU 5/0", 2'b01, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);             take("DIVU 5/0");
    run_op("REMU 5/0", 2'b11, 32'd5, 32'd0, 0, 32'd5);                     take("REMU 5/0");
    run_op("DIV -10/0", 2'b00, 32'hFFFF_FFF6, 32'd0, 0, 32'hFFFF_FFFF);    take("DIV -10/0");
    run_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000); take("DIV ovf");
    run_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);      take("REM ovf");

    run_op("DIVU max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold result", bus.result, 32'hFFFF_FFFF);
      check("hold resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("hold req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    take("DIVU max/1");

    // Flush ten cycles into CALC.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct = 2'b01; bus.op1 = 32'd100; bus.op2 = 32'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("flush resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen++;
    end
    check("flush no response", 32'(seen), 32'd0);
    run_op("REMU 20/3", 2'b11, 32'd20, 32'd3, 32, 32'd2);                  take("REMU 20/3");

    // Flush coinciding with a request handshake drops the request.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct = 2'b01; bus.op1 = 32'd9; bus.op2 = 32'd0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    flush = 1'b0;
    check("flush+req req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("flush+req resp_valid", {31'b0, bus.resp_valid}, 32'd0);

    // Reset ten cycles into CALC.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct = 2'b01; bus.op1 = 32'd100; bus.op2 = 32'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset mid result", bus.result, 32'd0);
    check("reset mid req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("reset mid resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    run_op("DIVU 20/3", 2'b01, 32'd20, 32'd3, 32, 32'd6);                  take("DIVU 20/3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
